// File: rtl/led_uart_tx.sv
// Purpose: watch the processor LED/result word and print each new value on a UART as 8 hex digits + CR LF.
// Latency: a change sampled at edge k drives the start bit after edge k+1 when idle; a frame is 100*DIV cycles.
// Backpressure: one value is buffered while a frame is in flight; newer values replace it and bump w_drop.
`timescale 1ns/1ps
module led_uart_tx #(
  parameter int DIV = 868
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_ce,
  input  logic [31:0] w_din,
  output logic        w_txd,
  output logic        w_busy,
  output logic [7:0]  w_drop
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_START   = 2'd1;
  localparam logic [1:0]  S_DATA    = 2'd2;
  localparam logic [1:0]  S_STOP    = 2'd3;
  localparam logic [15:0] BAUD_LAST = 16'(DIV - 1);
  localparam logic [3:0]  LAST_CHAR = 4'd9;

  logic [1:0]  state;
  logic [31:0] last_seen;
  logic [31:0] pend_val;
  logic        pend;
  logic [31:0] frame_word;
  logic [3:0]  char_idx;
  logic [2:0]  bit_idx;
  logic [7:0]  chr;
  logic [15:0] baud;
  logic        txd;
  logic [7:0]  drop;

  logic change;
  logic consume;
  logic baud_done;

  // Map a nibble to its uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) hex_ascii = 8'h30 + {4'h0, n};
    else           hex_ascii = 8'h37 + {4'h0, n};
  endfunction

  // Character idx of the frame: eight hex digits MSB nibble first, then CR, LF.
  function automatic logic [7:0] frame_char(input logic [31:0] w, input logic [3:0] idx);
    case (idx)
      4'd0:    frame_char = hex_ascii(w[31:28]);
      4'd1:    frame_char = hex_ascii(w[27:24]);
      4'd2:    frame_char = hex_ascii(w[23:20]);
      4'd3:    frame_char = hex_ascii(w[19:16]);
      4'd4:    frame_char = hex_ascii(w[15:12]);
      4'd5:    frame_char = hex_ascii(w[11:8]);
      4'd6:    frame_char = hex_ascii(w[7:4]);
      4'd7:    frame_char = hex_ascii(w[3:0]);
      4'd8:    frame_char = 8'h0D;
      default: frame_char = 8'h0A;
    endcase
  endfunction

  assign change    = w_ce && (w_din != last_seen);
  assign consume   = (state == S_IDLE) && pend;
  assign baud_done = (baud == BAUD_LAST);

  // Change detection and the single-entry pending buffer with saturating drop count.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      last_seen <= 32'h0;
      pend_val  <= 32'h0;
      pend      <= 1'b0;
      drop      <= 8'h00;
    end else if (change) begin
      last_seen <= w_din;
      pend_val  <= w_din;
      pend      <= 1'b1;
      // A value still waiting (and not being taken this edge) is lost.
      if (pend && !consume && (drop != 8'hFF)) drop <= drop + 8'd1;
    end else if (consume) begin
      pend <= 1'b0;
    end
  end

  // Transmit FSM: start bit, 8 data bits LSB first, stop bit, chained over 10 chars.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state      <= S_IDLE;
      frame_word <= 32'h0;
      char_idx   <= 4'd0;
      bit_idx    <= 3'd0;
      chr        <= 8'h00;
      baud       <= 16'd0;
      txd        <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          baud <= 16'd0;
          txd  <= 1'b1;
          if (pend) begin
            frame_word <= pend_val;
            char_idx   <= 4'd0;
            chr        <= frame_char(pend_val, 4'd0);
            txd        <= 1'b0;
            state      <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud    <= 16'd0;
            bit_idx <= 3'd0;
            txd     <= chr[0];
            chr     <= {1'b0, chr[7:1]};
            state   <= S_DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud <= 16'd0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= chr[0];
              chr     <= {1'b0, chr[7:1]};
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          if (baud_done) begin
            baud <= 16'd0;
            if (char_idx < LAST_CHAR) begin
              // Next char follows immediately: its start bit replaces this stop bit.
              char_idx <= char_idx + 4'd1;
              chr      <= frame_char(frame_word, char_idx + 4'd1);
              txd      <= 1'b0;
              state    <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
      endcase
    end
  end

  assign w_txd  = txd;
  assign w_busy = (state != S_IDLE);
  assign w_drop = drop;

endmodule

// File: tb/tb_led_uart_tx.sv
// Purpose: directed bench for led_uart_tx with DIV=4 (400-cycle frames).
// Latency: outputs sampled on the falling clock edge; inputs driven there too.
// Backpressure: exercises overwrite of the pending value and the drop counter.
`timescale 1ns/1ps
module tb_led_uart_tx;

  localparam int DIV = 4;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b0;
  logic        w_ce  = 1'b0;
  logic [31:0] w_din = 32'h0;
  logic        w_txd;
  logic        w_busy;
  logic [7:0]  w_drop;

  int checks   = 0;
  int failures = 0;

  logic [79:0] frame_dat;
  int          frame_err;
  int          busy_cnt;
  logic [79:0] exp_frame;

  led_uart_tx #(.DIV(DIV)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_ce  (w_ce),
    .w_din (w_din),
    .w_txd (w_txd),
    .w_busy(w_busy),
    .w_drop(w_drop)
  );

  always #5 w_clk = ~w_clk;

  // Records one frame starting at the falling edge inside the first start-bit cycle.
  // Ends at the falling edge of the first cycle after the frame.
  task automatic capture_frame();
    logic [7:0] by;
    logic       first;
    frame_err = 0;
    busy_cnt  = 0;
    frame_dat = '0;
    first     = 1'b0;
    for (int c = 0; c < 10; c++) begin
      by = 8'h00;
      for (int b = 0; b < 10; b++) begin
        for (int d = 0; d < DIV; d++) begin
          if (w_busy === 1'b1) busy_cnt++;
          if (d == 0) first = w_txd;
          else if (w_txd !== first) frame_err++;
          @(negedge w_clk);
        end
        if (b == 0 && first !== 1'b0) frame_err++;
        if (b == 9 && first !== 1'b1) frame_err++;
        if (b >= 1 && b <= 8) by[b-1] = first;
      end
      frame_dat = {frame_dat[71:0], by};
    end
  endtask

  task automatic wait_start(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      if (w_txd === 1'b0) found = 1'b1;
      else @(negedge w_clk);
    end
  endtask

  task automatic test_reset();
    int bad;
    w_rst = 1'b1;
    w_ce  = 1'b1;
    w_din = 32'h0;
    repeat (2) @(negedge w_clk);
    checks++;
    if (w_txd !== 1'b1 || w_busy !== 1'b0 || w_drop !== 8'd0) begin
      failures++;
      $display("FAIL reset_state txd=%b busy=%b drop=%0d want 1 0 0", w_txd, w_busy, w_drop);
    end
    w_rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge w_clk);
      if (w_txd !== 1'b1 || w_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || w_drop !== 8'd0) begin
      failures++;
      $display("FAIL idle_quiet bad_cycles=%0d drop=%0d want 0 0", bad, w_drop);
    end
  endtask

  task automatic test_single();
    w_din = 32'h000000A5;
    @(negedge w_clk);
    checks++;
    if (w_txd !== 1'b1) begin
      failures++;
      $display("FAIL single_early txd=%b want 1", w_txd);
    end
    @(negedge w_clk);
    checks++;
    if (w_txd !== 1'b0 || w_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_latency txd=%b busy=%b want 0 1", w_txd, w_busy);
    end
    capture_frame();
    exp_frame = 80'h30303030303041350D0A;
    checks++;
    if (frame_dat !== exp_frame) begin
      failures++;
      $display("FAIL single_bytes got=%h want=%h", frame_dat, exp_frame);
    end
    checks++;
    if (busy_cnt != 400 || w_busy !== 1'b0 || frame_err != 0) begin
      failures++;
      $display("FAIL single_busy busy_cycles=%0d busy_after=%b errs=%0d want 400 0 0",
               busy_cnt, w_busy, frame_err);
    end
  endtask

  task automatic test_hex_timing();
    w_din = 32'hDEADBEEF;
    repeat (2) @(negedge w_clk);
    checks++;
    if (w_txd !== 1'b0) begin
      failures++;
      $display("FAIL hex_latency txd=%b want 0", w_txd);
    end
    capture_frame();
    exp_frame = 80'h44454144424545460D0A;
    checks++;
    if (frame_dat !== exp_frame) begin
      failures++;
      $display("FAIL hex_bytes got=%h want=%h", frame_dat, exp_frame);
    end
    checks++;
    if (frame_err != 0) begin
      failures++;
      $display("FAIL hex_bit_timing errors=%0d want 0", frame_err);
    end
    checks++;
    if (busy_cnt != 400 || w_txd !== 1'b1 || w_busy !== 1'b0) begin
      failures++;
      $display("FAIL hex_end busy_cycles=%0d txd=%b busy=%b want 400 1 0", busy_cnt, w_txd, w_busy);
    end
  endtask

  task automatic test_overwrite();
    bit found;
    w_din = 32'h11;
    repeat (2) @(negedge w_clk);
    fork
      capture_frame();
      begin
        repeat (50) @(negedge w_clk);
        w_din = 32'h22;
        repeat (70) @(negedge w_clk);
        w_din = 32'h33;
      end
    join
    exp_frame = 80'h30303030303031310D0A;
    checks++;
    if (frame_dat !== exp_frame || frame_err != 0) begin
      failures++;
      $display("FAIL ovw_first got=%h errs=%0d want=%h 0", frame_dat, frame_err, exp_frame);
    end
    checks++;
    if (w_busy !== 1'b0 || w_txd !== 1'b1) begin
      failures++;
      $display("FAIL ovw_gap busy=%b txd=%b want 0 1", w_busy, w_txd);
    end
    wait_start(20, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL ovw_second_start found=0 want 1");
    end else begin
      capture_frame();
      exp_frame = 80'h30303030303033330D0A;
      if (frame_dat !== exp_frame || frame_err != 0) begin
        failures++;
        $display("FAIL ovw_second got=%h errs=%0d want=%h 0", frame_dat, frame_err, exp_frame);
      end
    end
    checks++;
    if (w_drop !== 8'd1) begin
      failures++;
      $display("FAIL ovw_drop got=%0d want 1", w_drop);
    end
  endtask

  task automatic test_reset_midframe();
    w_din = 32'h5;
    repeat (2) @(negedge w_clk);
    repeat (150) @(negedge w_clk);
    w_rst = 1'b1;
    @(negedge w_clk);
    checks++;
    if (w_txd !== 1'b1 || w_busy !== 1'b0 || w_drop !== 8'd0) begin
      failures++;
      $display("FAIL midrst_state txd=%b busy=%b drop=%0d want 1 0 0", w_txd, w_busy, w_drop);
    end
    w_rst = 1'b0;
    @(negedge w_clk);
    checks++;
    if (w_txd !== 1'b1) begin
      failures++;
      $display("FAIL midrst_early txd=%b want 1", w_txd);
    end
    @(negedge w_clk);
    checks++;
    if (w_txd !== 1'b0 || w_busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_restart txd=%b busy=%b want 0 1", w_txd, w_busy);
    end
    capture_frame();
    exp_frame = 80'h30303030303030350D0A;
    checks++;
    if (frame_dat !== exp_frame || frame_err != 0) begin
      failures++;
      $display("FAIL midrst_bytes got=%h errs=%0d want=%h 0", frame_dat, frame_err, exp_frame);
    end
  endtask

  task automatic test_enable();
    int bad;
    w_ce  = 1'b0;
    w_din = 32'h7;
    bad   = 0;
    repeat (60) begin
      @(negedge w_clk);
      if (w_txd !== 1'b1 || w_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ce_gated active_cycles=%0d want 0", bad);
    end
    w_ce = 1'b1;
    @(negedge w_clk);
    checks++;
    if (w_txd !== 1'b1) begin
      failures++;
      $display("FAIL ce_early txd=%b want 1", w_txd);
    end
    @(negedge w_clk);
    checks++;
    if (w_txd !== 1'b0) begin
      failures++;
      $display("FAIL ce_latency txd=%b want 0", w_txd);
    end
    capture_frame();
    exp_frame = 80'h30303030303030370D0A;
    checks++;
    if (frame_dat !== exp_frame || frame_err != 0 || busy_cnt != 400) begin
      failures++;
      $display("FAIL ce_bytes got=%h errs=%0d busy=%0d want=%h 0 400",
               frame_dat, frame_err, busy_cnt, exp_frame);
    end
  endtask

  initial begin
    @(negedge w_clk);
    test_reset();
    test_single();
    test_hex_timing();
    test_overwrite();
    test_reset_midframe();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_uart_tx.md
Name: led_uart_tx

Overview:
Downstream consumer of the processor's 32-bit LED/result output (the r_led value driven on w_led/w_dout). Detects each change of that value and transmits it over a UART TX line as 8 uppercase ASCII hex digits followed by CR LF. Sits beside the VIO in m_main so the running program can be observed on a serial terminal. Buffers one pending value while a frame is in flight.

Parameters:
DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535

Ports:
w_clk  in  1  system clock (w_clk2 domain)
w_rst  in  1  synchronous active-high reset
w_ce   in  1  sample enable (tied to w_locked); low = ignore w_din changes
w_din  in  32 processor LED/result value
w_txd  out 1  UART serial output, idle high
w_busy out 1  high while a frame is being transmitted
w_drop out 8  count of values overwritten before being sent, saturating

Behaviour:
- Reset (synchronous, w_rst=1 at a rising edge): after that edge w_txd=1, w_busy=0, w_drop=0; internal last-seen value=0, pending flag=0, state=IDLE. Applies mid-frame: the frame is aborted, TX returns high and the frame does not resume.
- Change detect: at each edge with w_ce=1 and w_din != last-seen, do three things: last-seen<=w_din, pending value<=w_din, pending<=1. w_ce=0 means no sampling; a frame in flight still completes.
- Overwrite: if pending=1 and is not being consumed in that same edge, a new change replaces the pending value and w_drop increments. w_drop saturates at 255. Only the latest value is kept.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if pending=1, at the next edge do the following: snapshot the pending value into the frame word, clear pending, set char index=0, load the char, drive w_txd=0, go to START.
  - If a new change arrives on the same edge that IDLE consumes pending, it sets pending again and is not counted as a drop.
  - START: hold the bit for DIV cycles, then go to DATA.
  - DATA: send 8 bits LSB first, each held DIV cycles, then go to STOP.
  - STOP: w_txd=1 for DIV cycles.
  - At the end of STOP: if char index<9, increment the index and go directly to START with the next char, with no gap. Otherwise go to IDLE.
  - IDLE always lasts at least 1 cycle between frames.
- Frame content: 10 chars.
  - Chars 0..7 are nibbles [31:28] down to [3:0] of the snapshot word. 0-9 map to 0x30-0x39; 10-15 map to 0x41-0x46.
  - Char 8 is 0x0D. Char 9 is 0x0A.
- Latency: w_din changes and is sampled at edge k. w_txd falls after edge k+1, assuming IDLE with nothing pending.
- Frame length: exactly 100*DIV cycles of w_busy=1.
- w_busy=1 in every state except IDLE. w_txd is registered and glitch-free. The bit counter and baud counter wrap without off-by-one: each bit is exactly DIV cycles.
- Arithmetic: the baud counter is 16-bit unsigned.

Test Plan:
(All with DIV=4, i.e. 400-cycle frames.)
1. Idle after reset: reset, then w_din=0, w_ce=1 for 1000 cycles -> w_txd stays 1, w_busy stays 0, w_drop=0.
2. Single value: w_din=0x000000A5 -> w_txd low 2 edges after the change; decoded bytes are 30 30 30 30 30 30 41 35 0D 0A; w_busy high exactly 400 cycles.
3. Bit timing and hex case: w_din=0xDEADBEEF -> every bit exactly 4 cycles, stop bits high; bytes are 44 45 41 44 42 45 45 46 0D 0A.
4. Overwrite:
   - Stimulus: w_din=0x11; at cycle 50 of its frame set 0x22; at cycle 120 set 0x33.
   - Response: frame "00000011", then ≥1 idle cycle, then frame "00000033"; 0x22 never sent; w_drop=1.
5. Reset mid-frame:
   - Stimulus: assert w_rst at cycle 150 of a frame for w_din=0x5, holding w_din=0x5.
   - Response: w_txd=1 and w_busy=0 after the reset edge. Release reset -> new frame "00000005" starts 2 edges later, because last-seen was reset to 0.
6. Enable gating: w_ce=0 while w_din goes 0->0x7 -> no frame; raise w_ce=1 -> frame "00000007" starts 2 edges later.
